// File: rtl/dds_pkg.sv
// dds_pkg: shared types and width check for the DDS waveform generator
package dds_pkg;

    typedef enum logic [1:0] {
        MODE_ZERO = 2'd0,
        MODE_TRI  = 2'd1,
        MODE_SAW  = 2'd2,
        MODE_SQR  = 2'd3
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_e;

    // The triangle shaper needs OUT_W magnitude bits plus one half-period bit.
    function automatic bit widths_ok(input int phase_w, input int out_w);
        return phase_w >= out_w + 1;
    endfunction

endpackage

// File: rtl/dds_wave_shaper.sv
// dds_wave_shaper: combinational phase-to-amplitude mapping for all modes
module dds_wave_shaper
    import dds_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 16
) (
    input  logic [PHASE_W-1:0] p_i,
    input  mode_e              mode_i,
    input  logic [PHASE_W-1:0] duty_i,
    output logic [OUT_W-1:0]   wave_o
);

    logic [OUT_W:0] u;

    assign u = p_i[PHASE_W-1 -: OUT_W+1];

    // Triangle folds the second half-period; square compares the full phase.
    always_comb begin
        wave_o = (mode_i == MODE_TRI) ? (u[OUT_W] ? ~u[OUT_W-1:0] : u[OUT_W-1:0]) :
                 (mode_i == MODE_SAW) ? p_i[PHASE_W-1 -: OUT_W] :
                 (mode_i == MODE_SQR) ? {OUT_W{p_i < duty_i}} : '0;
    end

endmodule

// File: rtl/dds_wave_gen.sv
// dds_wave_gen: phase-accumulator DDS with immediate or wrap-synchronous retune
module dds_wave_gen
    import dds_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               sync,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_step,
    input  logic [PHASE_W-1:0] cfg_phase,
    input  logic [PHASE_W-1:0] cfg_duty,
    input  logic [1:0]         cfg_mode,
    input  logic               cfg_on_wrap,
    output logic [OUT_W-1:0]   wave_out,
    output logic               wave_valid,
    output logic               wrap
);

    if (!widths_ok(PHASE_W, OUT_W)) begin : g_bad_widths
        $error("dds_wave_gen: PHASE_W must be at least OUT_W+1");
    end

    logic [PHASE_W-1:0] acc_q, acc_d, step_q, phase_q, duty_q, p_q;
    logic [PHASE_W-1:0] pstep_q, pphase_q, pduty_q;
    mode_e              mode_q, pmode_q;
    state_e             state_q, state_d;
    logic [PHASE_W:0]   sum;
    logic               carry, load_now, take_pend, apply_pend;
    logic               v1_q, valid_q, wrap_q;
    logic [OUT_W-1:0]   wave_q, shaped;

    assign sum   = {1'b0, acc_q} + {1'b0, step_q};
    assign carry = en & sum[PHASE_W];
    assign acc_d = sync ? '0 : en ? sum[PHASE_W-1:0] : acc_q;

    // Config handshake: immediate loads stay in IDLE, wrap loads park in PEND.
    always_comb begin
        state_d    = state_q;
        cfg_ready  = (state_q == IDLE);
        load_now   = 1'b0;
        take_pend  = 1'b0;
        apply_pend = 1'b0;
        if (state_q == IDLE && cfg_valid) begin
            load_now  = !cfg_on_wrap;
            take_pend = cfg_on_wrap;
            state_d   = cfg_on_wrap ? PEND : IDLE;
        end
        if (state_q == PEND && (sync || carry)) begin
            apply_pend = 1'b1;
            state_d    = IDLE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Active and pending configuration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q   <= '0;
            phase_q  <= '0;
            duty_q   <= '0;
            mode_q   <= MODE_ZERO;
            pstep_q  <= '0;
            pphase_q <= '0;
            pduty_q  <= '0;
            pmode_q  <= MODE_ZERO;
        end else begin
            if (load_now) begin
                step_q  <= cfg_step;
                phase_q <= cfg_phase;
                duty_q  <= cfg_duty;
                mode_q  <= mode_e'(cfg_mode);
            end else if (apply_pend) begin
                step_q  <= pstep_q;
                phase_q <= pphase_q;
                duty_q  <= pduty_q;
                mode_q  <= pmode_q;
            end
            if (take_pend) begin
                pstep_q  <= cfg_step;
                pphase_q <= cfg_phase;
                pduty_q  <= cfg_duty;
                pmode_q  <= mode_e'(cfg_mode);
            end
        end
    end

    dds_wave_shaper #(.PHASE_W(PHASE_W), .OUT_W(OUT_W)) u_shaper (
        .p_i    (p_q),
        .mode_i (mode_q),
        .duty_i (duty_q),
        .wave_o (shaped)
    );

    // Accumulator plus the two free-running pipeline stages; sync does not flush them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            wrap_q  <= 1'b0;
            p_q     <= '0;
            v1_q    <= 1'b0;
            wave_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            wrap_q  <= carry & ~sync;
            p_q     <= acc_q + phase_q;
            v1_q    <= en;
            wave_q  <= shaped;
            valid_q <= v1_q;
        end
    end

    assign wave_out   = wave_q;
    assign wave_valid = valid_q;
    assign wrap       = wrap_q;

endmodule
